interpo_coef_sequencer: RTL
===========================

# interpo_coef_sequencer

Sequencer for the second (s2) port of a 32-word × 32-bit interpolation coefficient RAM. On a start pulse it reads a programmed run of coefficients from a base address, wrapping modulo 32, and streams them to the interpolation datapath over a valid/ready handshake. The RAM's s1 port stays with the host for coefficient loading. This block owns s2 exclusively and only reads through it.

## Interface
- ADDR_W, 5, RAM address width; depth is 2^ADDR_W.
- DATA_W, 32, coefficient width.
- clk  in  1  single clock for the block and the RAM s2 port.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle run request; ignored while busy=1.
- abort  in  1  terminates the current run.
- base_addr  in  ADDR_W  first RAM word of the run; sampled with start.
- tap_count  in  ADDR_W+1  number of words to read; sampled with start.
- busy  out  1  a run is in progress.
- done  out  1  one-cycle pulse at normal run completion.
- ram_address  out  ADDR_W  s2 address.
- ram_chipselect  out  1  s2 read strobe.
- ram_write  out  1  tied to 0.
- ram_byteenable  out  4  tied to 4'hF.
- ram_readdata  in  DATA_W  s2 data.
  - Unregistered output with registered address, so data is valid the cycle after the address is presented.
- coef_data  out  DATA_W  coefficient to the datapath.
- coef_index  out  ADDR_W  tap number within the run, 0..N-1.
- coef_valid  out  1  coef_data/coef_index are valid.
- coef_ready  in  1  datapath accepts; a transfer occurs when coef_valid & coef_ready.

## Operation
- States:
  - IDLE: busy=0. start=1 latches base_addr and N = min(tap_count, 32), then moves to RUN.
    - If tap_count == 0: no reads are issued, and the FSM goes to DONE instead of RUN.
  - RUN: busy=1. Issues reads, buffers data and streams it out.
    - When N transfers have completed, moves to DONE.
  - DONE: done=1 for one cycle, then IDLE. busy is still 1 in this cycle.
- Read issue rules:
  - Issue counter i runs 0..N-1 and ram_address = (base + i) mod 32.
  - ram_chipselect=1 only when (entries in output FIFO + reads in flight) < 2 and i < N.
  - At most one read is in flight at a time; read latency is 1.
- Output FIFO:
  - 2 entries, registered output, holding data plus index.
  - Returned data is written the cycle after its read.
  - Overflow is impossible by the issue rule.
- Throughput: with coef_ready held at 1, one coefficient is transferred per cycle.
- Backpressure: while coef_ready=0, coef_valid, coef_data and coef_index hold stable until the transfer.
- start while busy: ignored, with no effect on the current run.
- abort, any state except IDLE:
  - Next state is IDLE.
  - FIFO and the in-flight read are discarded, and coef_valid drops the next cycle.
  - No done pulse.
  - abort and start in the same IDLE cycle: start is ignored.
- Reset values: busy=0, done=0, coef_valid=0, coef_data=0, coef_index=0, ram_chipselect=0, ram_address=0; FSM=IDLE.
- reset_n asserted mid-run: everything clears immediately and asynchronously, and no done pulse follows.

## Timing
- Cycle numbering:
  - Cycle 0: start=1.
  - Cycle 1: busy=1, ram_chipselect=1, ram_address=base.
  - Cycle 2: ram_readdata holds word base.
  - Cycle 3: coef_valid=1, coef_index=0.
- With coef_ready=1 throughout:
  - Tap k is valid in cycle 3+k.
  - done=1 in cycle 3+N, and busy falls in cycle 4+N.
- tap_count=0: busy=1 and done=1 in cycle 1, with no chipselect; busy=0 in cycle 2.
- The earliest new start is accepted in the cycle busy reads 0.
- ram_chipselect deasserts in the same cycle the issue condition fails. It is never asserted in IDLE or DONE.

## Test plan
- Basic run with coef_ready=1, base=4, tap_count=8 (RAM preloaded with word i = 0xA000_0000+i):
  - Required: 0xA000_0004..0xA000_000B with index 0..7 in cycles 3..10.
  - Required: done in cycle 11 and exactly 8 chipselect cycles.
- Wrap with base=30, tap_count=4:
  - Required: addresses 30, 31, 0, 1 and data order preserved.
- Backpressure with base=0, tap_count=6 and coef_ready toggling 1,0,0,1,…:
  - Required: no data lost or duplicated, coef_data stable while stalled, and never more than 2 reads outstanding or buffered.
- Limits:
  - tap_count=0: done in cycle 1 and no chipselect.
  - tap_count=40: clamped to 32, so exactly 32 transfers.
- Interference:
  - start pulse mid-run: ignored.
  - abort after the 3rd transfer: coef_valid=0 the next cycle, busy=0 and no done.
  - A following start with base=0, tap_count=2 runs correctly.
- Reset: reset_n low mid-run asynchronously clears all outputs to their reset values, and a fresh run completes normally afterwards.

Source files
------------

// File: rtl/interpo_coef_sequencer.sv
// Read-only sequencer for the s2 port of the interpolation coefficient RAM.
// Streams a programmed run of coefficients (wrapping modulo depth) over valid/ready.
module interpo_coef_sequencer #(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   tap_count,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_chipselect,
  output logic              ram_write,
  output logic [3:0]        ram_byteenable,
  input  logic [DATA_W-1:0] ram_readdata,
  output logic [DATA_W-1:0] coef_data,
  output logic [ADDR_W-1:0] coef_index,
  output logic              coef_valid,
  input  logic              coef_ready
);

  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] base;
  logic [ADDR_W:0]   n, issue_cnt, xfer_cnt;
  logic              inflight;
  logic [ADDR_W-1:0] inflight_idx;
  logic [1:0]        fifo_cnt;
  logic [DATA_W-1:0] d1_data;
  logic [ADDR_W-1:0] d1_idx;
  logic              accept, flush, pop, push, issue;
  logic [2:0]        occ;

  assign accept     = (state == S_IDLE) && start && !abort;
  assign flush      = (state != S_IDLE) && abort;
  assign coef_valid = (fifo_cnt != 2'd0);
  assign pop        = coef_valid && coef_ready;
  assign push       = inflight;

  // Occupancy counts the slot freed by a same-cycle pop so a ready sink sees one word per cycle.
  assign occ   = {1'b0, fifo_cnt} - {2'b00, pop} + {2'b00, inflight};
  assign issue = (state == S_RUN) && (issue_cnt < n) && (occ < 3'd2);

  assign busy           = (state != S_IDLE);
  assign done           = (state == S_DONE);
  assign ram_chipselect = issue;
  assign ram_address    = (state == S_RUN) ? base + issue_cnt[ADDR_W-1:0] : '0;
  assign ram_write      = 1'b0;
  assign ram_byteenable = 4'hF;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (accept) state_nxt = (tap_count == '0) ? S_DONE : S_RUN;
      S_RUN: begin
        if (abort)                                state_nxt = S_IDLE;
        else if (pop && (xfer_cnt + 1'b1 == n))   state_nxt = S_DONE;
      end
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      base         <= '0;
      n            <= '0;
      issue_cnt    <= '0;
      xfer_cnt     <= '0;
      inflight     <= 1'b0;
      inflight_idx <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        base      <= base_addr;
        n         <= (tap_count > DEPTH) ? DEPTH : tap_count;
        issue_cnt <= '0;
        xfer_cnt  <= '0;
      end else begin
        if (issue) issue_cnt <= issue_cnt + 1'b1;
        if (pop)   xfer_cnt  <= xfer_cnt + 1'b1;
      end
      inflight     <= issue && !flush;
      inflight_idx <= issue_cnt[ADDR_W-1:0];
    end
  end

  // Two-entry FIFO: the head register drives coef_data/coef_index directly.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_cnt   <= '0;
      coef_data  <= '0;
      coef_index <= '0;
      d1_data    <= '0;
      d1_idx     <= '0;
    end else if (flush) begin
      fifo_cnt <= '0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (fifo_cnt == 2'd0) begin
            coef_data  <= ram_readdata;
            coef_index <= inflight_idx;
          end else begin
            d1_data <= ram_readdata;
            d1_idx  <= inflight_idx;
          end
          fifo_cnt <= fifo_cnt + 2'd1;
        end
        2'b01: begin
          coef_data  <= d1_data;
          coef_index <= d1_idx;
          fifo_cnt   <= fifo_cnt - 2'd1;
        end
        2'b11: begin
          if (fifo_cnt == 2'd2) begin
            coef_data  <= d1_data;
            coef_index <= d1_idx;
            d1_data    <= ram_readdata;
            d1_idx     <= inflight_idx;
          end else begin
            coef_data  <= ram_readdata;
            coef_index <= inflight_idx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
